// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU/MDU opcodes, register-file
// address width and the multiply/divide unit state machine.
package ex_stage_pkg;

  localparam int CORE_RF_W     = 5;
  localparam int CORE_ALU_OP_W = 5;

  // Single-cycle ops live in 0..10; every RV32M op has bit 4 set and bit 3 clear.
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_ADD    = 5'd0;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SUB    = 5'd1;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SLL    = 5'd2;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SLT    = 5'd3;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SLTU   = 5'd4;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_XOR    = 5'd5;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SRL    = 5'd6;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SRA    = 5'd7;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_OR     = 5'd8;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_AND    = 5'd9;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_PASSB  = 5'd10;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_MUL    = 5'd16;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_MULH   = 5'd17;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_MULHSU = 5'd18;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_MULHU  = 5'd19;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_DIV    = 5'd20;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_DIVU   = 5'd21;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_REM    = 5'd22;
  localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_REMU   = 5'd23;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic core_alu_is_mdu(input logic [CORE_ALU_OP_W-1:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/ex_stage_mdu.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand
// magnitudes, with the sign applied to the final value.
module ex_stage_mdu
  import ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MDU_ITER = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CORE_ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]          a,
  input  logic [XLEN-1:0]          b,
  output logic                     busy,
  output logic                     done,
  output logic [XLEN-1:0]          result,
  output mdu_state_e               state
);

  // Handshake: start is a level request honoured only in IDLE; busy is high
  // from the accepting cycle until DONE; done is a one-cycle strobe with result valid.
  localparam int CW = $clog2(MDU_ITER);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q;
  logic [CORE_ALU_OP_W-1:0]  op_q;
  logic [2*XLEN-1:0]         acc_q, mcand_q, product;
  logic [XLEN-1:0]           mplier_q, a_mag, b_mag, quot, rem;
  logic                      neg_q, neg_rem_q;
  logic                      a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [XLEN:0]             rem_shift, rem_diff;
  logic [2*XLEN-1:0]         div_next;

  always_comb begin
    a_signed = (op == CORE_ALU_OP_MUL) || (op == CORE_ALU_OP_MULH) ||
               (op == CORE_ALU_OP_MULHSU) || (op == CORE_ALU_OP_DIV) || (op == CORE_ALU_OP_REM);
    b_signed = (op == CORE_ALU_OP_MUL) || (op == CORE_ALU_OP_MULH) ||
               (op == CORE_ALU_OP_DIV) || (op == CORE_ALU_OP_REM);
    is_div   = op[2];
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && b_signed && (a == XMIN) && (b == '1);
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      MDU_IDLE: if (start) begin
        busy    = 1'b1;
        state_d = (div_zero || div_ovf) ? MDU_DONE : MDU_BUSY;
      end
      MDU_BUSY: begin
        busy = 1'b1;
        if (cnt_q == CW'(MDU_ITER - 1)) state_d = MDU_DONE;
      end
      MDU_DONE: begin
        done    = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MDU_IDLE;
    else      state_q <= state_d;
  end

  // Divide keeps {remainder, dividend/quotient} in acc_q and the divisor in mcand_q.
  always_comb begin
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, mcand_q[XLEN-1:0]};
    if (!rem_diff[XLEN]) div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                 div_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == MDU_IDLE && start) begin
      op_q      <= op;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      if (div_zero) begin
        acc_q <= {a, {XLEN{1'b1}}};
      end else if (div_ovf) begin
        acc_q <= {{XLEN{1'b0}}, XMIN};
      end else if (is_div) begin
        acc_q     <= {{XLEN{1'b0}}, a_mag};
        mcand_q   <= {{XLEN{1'b0}}, b_mag};
        neg_q     <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
      end else begin
        acc_q    <= '0;
        mcand_q  <= {{XLEN{1'b0}}, a_mag};
        mplier_q <= b_mag;
        neg_q    <= a_neg ^ b_neg;
      end
    end else if (state_q == MDU_BUSY) begin
      cnt_q <= cnt_q + CW'(1);
      if (op_q[2]) begin
        acc_q <= div_next;
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

  always_comb begin
    product = neg_q ? -acc_q : acc_q;
    quot    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem     = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q[2:0])
      3'd0:       result = product[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       result = product[2*XLEN-1:XLEN];
      3'd4, 3'd5: result = quot;
      default:    result = rem;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MDU and the
// ex2mem pipeline register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MDU_ITER = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id2ex_reg_wen,
  input  logic [CORE_RF_W-1:0]     id2ex_reg_waddr,
  input  logic [XLEN-1:0]          id2ex_reg_rs1_data,
  input  logic [XLEN-1:0]          id2ex_reg_rs2_data,
  input  logic [XLEN-1:0]          id2ex_imm_value,
  input  logic [CORE_ALU_OP_W-1:0] id2ex_alu_op,
  input  logic                     id2ex_sel_imm,
  input  logic                     id2ex_rs1_forward_from_mem,
  input  logic                     id2ex_rs2_forward_from_mem,
  input  logic                     id2ex_rs1_forward_from_wb,
  input  logic                     id2ex_rs2_forward_from_wb,
  input  logic                     id2ex_ill_instr,
  input  logic [XLEN-1:0]          reg_wdata,
  output logic                     ex2mem_reg_wen,
  output logic [CORE_RF_W-1:0]     ex2mem_reg_waddr,
  output logic [XLEN-1:0]          ex2mem_alu_result,
  output logic                     ex2mem_ill_instr,
  output logic                     ex_stall,
  output mdu_state_e               mdu_state
);

  logic [XLEN-1:0] op_a, op_b, rs2_fwd, alu_result, mdu_result;
  logic [4:0]      shamt;
  logic            mdu_start, mdu_busy, mdu_done;

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    op_a = id2ex_reg_rs1_data;
    if (id2ex_rs1_forward_from_mem)     op_a = ex2mem_alu_result;
    else if (id2ex_rs1_forward_from_wb) op_a = reg_wdata;
    rs2_fwd = id2ex_reg_rs2_data;
    if (id2ex_rs2_forward_from_mem)     rs2_fwd = ex2mem_alu_result;
    else if (id2ex_rs2_forward_from_wb) rs2_fwd = reg_wdata;
    op_b  = id2ex_sel_imm ? id2ex_imm_value : rs2_fwd;
    shamt = op_b[4:0];
  end

  always_comb begin
    alu_result = '0;
    unique case (id2ex_alu_op)
      CORE_ALU_OP_ADD:   alu_result = op_a + op_b;
      CORE_ALU_OP_SUB:   alu_result = op_a - op_b;
      CORE_ALU_OP_SLL:   alu_result = op_a << shamt;
      CORE_ALU_OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CORE_ALU_OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      CORE_ALU_OP_XOR:   alu_result = op_a ^ op_b;
      CORE_ALU_OP_SRL:   alu_result = op_a >> shamt;
      CORE_ALU_OP_SRA:   alu_result = $unsigned($signed(op_a) >>> shamt);
      CORE_ALU_OP_OR:    alu_result = op_a | op_b;
      CORE_ALU_OP_AND:   alu_result = op_a & op_b;
      CORE_ALU_OP_PASSB: alu_result = op_b;
      default:           alu_result = '0;
    endcase
  end

  assign mdu_start = id2ex_reg_wen & core_alu_is_mdu(id2ex_alu_op);
  assign ex_stall  = mdu_busy;

  ex_stage_mdu #(
    .XLEN     (XLEN),
    .MDU_ITER (MDU_ITER)
  ) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .op     (id2ex_alu_op),
    .a      (op_a),
    .b      (op_b),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_result),
    .state  (mdu_state)
  );

  // A stall inserts a bubble; address and data hold so MEM sees a stable value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex2mem_reg_wen    <= 1'b0;
      ex2mem_reg_waddr  <= '0;
      ex2mem_alu_result <= '0;
      ex2mem_ill_instr  <= 1'b0;
    end else if (ex_stall) begin
      ex2mem_reg_wen   <= 1'b0;
      ex2mem_ill_instr <= 1'b0;
    end else begin
      ex2mem_reg_wen    <= id2ex_reg_wen;
      ex2mem_reg_waddr  <= id2ex_reg_waddr;
      ex2mem_alu_result <= mdu_done ? mdu_result : alu_result;
      ex2mem_ill_instr  <= id2ex_ill_instr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, hand-written MDU/reset sequences
// and randomized ops checked against an arithmetic reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id2ex_reg_wen;
  logic [4:0]  id2ex_reg_waddr;
  logic [31:0] id2ex_reg_rs1_data, id2ex_reg_rs2_data, id2ex_imm_value;
  logic [4:0]  id2ex_alu_op;
  logic        id2ex_sel_imm;
  logic        id2ex_rs1_forward_from_mem, id2ex_rs2_forward_from_mem;
  logic        id2ex_rs1_forward_from_wb, id2ex_rs2_forward_from_wb;
  logic        id2ex_ill_instr;
  logic [31:0] reg_wdata;
  logic        ex2mem_reg_wen;
  logic [4:0]  ex2mem_reg_waddr;
  logic [31:0] ex2mem_alu_result;
  logic        ex2mem_ill_instr;
  logic        ex_stall;
  mdu_state_e  mdu_state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp;

  ex_stage #(.XLEN(32), .MDU_ITER(32)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .id2ex_reg_wen              (id2ex_reg_wen),
    .id2ex_reg_waddr            (id2ex_reg_waddr),
    .id2ex_reg_rs1_data         (id2ex_reg_rs1_data),
    .id2ex_reg_rs2_data         (id2ex_reg_rs2_data),
    .id2ex_imm_value            (id2ex_imm_value),
    .id2ex_alu_op               (id2ex_alu_op),
    .id2ex_sel_imm              (id2ex_sel_imm),
    .id2ex_rs1_forward_from_mem (id2ex_rs1_forward_from_mem),
    .id2ex_rs2_forward_from_mem (id2ex_rs2_forward_from_mem),
    .id2ex_rs1_forward_from_wb  (id2ex_rs1_forward_from_wb),
    .id2ex_rs2_forward_from_wb  (id2ex_rs2_forward_from_wb),
    .id2ex_ill_instr            (id2ex_ill_instr),
    .reg_wdata                  (reg_wdata),
    .ex2mem_reg_wen             (ex2mem_reg_wen),
    .ex2mem_reg_waddr           (ex2mem_reg_waddr),
    .ex2mem_alu_result          (ex2mem_alu_result),
    .ex2mem_ill_instr           (ex2mem_ill_instr),
    .ex_stall                   (ex_stall),
    .mdu_state                  (mdu_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] ea, eb, ua, ub, p;
    sa = a;
    sb = b;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (op)
      CORE_ALU_OP_ADD:   return a + b;
      CORE_ALU_OP_SUB:   return a - b;
      CORE_ALU_OP_SLL:   return a << b[4:0];
      CORE_ALU_OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      CORE_ALU_OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      CORE_ALU_OP_XOR:   return a ^ b;
      CORE_ALU_OP_SRL:   return a >> b[4:0];
      CORE_ALU_OP_SRA:   return sa >>> b[4:0];
      CORE_ALU_OP_OR:    return a | b;
      CORE_ALU_OP_AND:   return a & b;
      CORE_ALU_OP_PASSB: return b;
      CORE_ALU_OP_MUL:    begin p = ea * eb; return p[31:0];  end
      CORE_ALU_OP_MULH:   begin p = ea * eb; return p[63:32]; end
      CORE_ALU_OP_MULHSU: begin p = ea * ub; return p[63:32]; end
      CORE_ALU_OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      CORE_ALU_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      CORE_ALU_OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      CORE_ALU_OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      CORE_ALU_OP_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_stall(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic is_div, is_sdiv;
    is_div  = (op == CORE_ALU_OP_DIV) || (op == CORE_ALU_OP_DIVU) ||
              (op == CORE_ALU_OP_REM) || (op == CORE_ALU_OP_REMU);
    is_sdiv = (op == CORE_ALU_OP_DIV) || (op == CORE_ALU_OP_REM);
    if (is_div && (b == 32'd0 || (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic sel, input logic f1m, input logic f1w,
                           input logic f2m, input logic f2w, input logic [31:0] wdata,
                           input logic wen, input logic [4:0] waddr, input logic ill);
    id2ex_alu_op               = op;
    id2ex_reg_rs1_data         = rs1;
    id2ex_reg_rs2_data         = rs2;
    id2ex_imm_value            = imm;
    id2ex_sel_imm              = sel;
    id2ex_rs1_forward_from_mem = f1m;
    id2ex_rs1_forward_from_wb  = f1w;
    id2ex_rs2_forward_from_mem = f2m;
    id2ex_rs2_forward_from_wb  = f2w;
    reg_wdata                  = wdata;
    id2ex_reg_wen              = wen;
    id2ex_reg_waddr            = waddr;
    id2ex_ill_instr            = ill;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mdu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fwd_wb, input logic scramble, input string name);
    logic [31:0] exp;
    logic [4:0]  waddr;
    int          exp_stall, n;
    exp       = model(op, a, b);
    exp_stall = model_stall(op, a, b);
    waddr     = 5'($urandom_range(1, 31));
    set_instr(op, fwd_wb ? ~a : a, b, 32'd0, 1'b0, 1'b0, fwd_wb, 1'b0, 1'b0,
              fwd_wb ? a : 32'd0, 1'b1, waddr, 1'b0);
    #1;
    check({name, "_idle_at_start"}, 32'(mdu_state), 32'(MDU_IDLE));
    check({name, "_stall_start"}, 32'(ex_stall), 32'd1);
    n = 0;
    while (ex_stall && n < 100) begin
      tick();
      n++;
      if (scramble) reg_wdata = $urandom;
    end
    check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check({name, "_bubble_wen"}, 32'(ex2mem_reg_wen), 32'd0);
    tick();
    check({name, "_result"}, ex2mem_alu_result, exp);
    check({name, "_wen"}, 32'(ex2mem_reg_wen), 32'd1);
    check({name, "_waddr"}, 32'(ex2mem_reg_waddr), 32'(waddr));
    last_exp = exp;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] rs1, rs2, imm;
    logic        sel, f1m, f1w, f2m, f2w;
    logic [31:0] wdata;
    logic        wen;
    logic [4:0]  waddr;
    logic        ill;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  logic [4:0] op_list[19];

  initial begin
    vecs[0]  = '{CORE_ALU_OP_ADD,   32'd5,        32'd0,  32'hFFFF_FFFD, 1,0,0,0,0, 32'd0,  1, 5'd3,  0, 32'd2};
    vecs[1]  = '{CORE_ALU_OP_ADD,   32'h10,       32'd0,  32'd0,         1,0,0,0,0, 32'd0,  1, 5'd4,  0, 32'h10};
    vecs[2]  = '{CORE_ALU_OP_SUB,   32'h55,       32'd1,  32'd0,         0,1,1,0,0, 32'h99, 1, 5'd5,  0, 32'hF};
    vecs[3]  = '{CORE_ALU_OP_SUB,   32'h55,       32'd1,  32'd0,         0,0,1,0,0, 32'h99, 1, 5'd6,  0, 32'h98};
    vecs[4]  = '{CORE_ALU_OP_SLL,   32'd1,        32'h23, 32'd0,         0,0,0,0,0, 32'd0,  1, 5'd7,  0, 32'd8};
    vecs[5]  = '{CORE_ALU_OP_SRA,   32'h8000_0000,32'd4,  32'd0,         0,0,0,0,0, 32'd0,  1, 5'd8,  0, 32'hF800_0000};
    vecs[6]  = '{CORE_ALU_OP_SRL,   32'h8000_0000,32'd4,  32'd0,         0,0,0,0,0, 32'd0,  1, 5'd9,  0, 32'h0800_0000};
    vecs[7]  = '{CORE_ALU_OP_SLT,   32'hFFFF_FFFF,32'd1,  32'd0,         0,0,0,0,0, 32'd0,  1, 5'd10, 0, 32'd1};
    vecs[8]  = '{CORE_ALU_OP_SLTU,  32'hFFFF_FFFF,32'd1,  32'd0,         0,0,0,0,0, 32'd0,  1, 5'd11, 0, 32'd0};
    vecs[9]  = '{CORE_ALU_OP_XOR,   32'hF0F0,     32'hFF, 32'd0,         0,0,0,0,0, 32'd0,  1, 5'd12, 0, 32'hF00F};
    vecs[10] = '{CORE_ALU_OP_OR,    32'hF0,       32'h0F, 32'd0,         0,0,0,0,0, 32'd0,  1, 5'd13, 0, 32'hFF};
    vecs[11] = '{CORE_ALU_OP_AND,   32'hF0,       32'h3C, 32'd0,         0,0,0,0,0, 32'd0,  1, 5'd14, 0, 32'h30};
    vecs[12] = '{CORE_ALU_OP_PASSB, 32'h777,      32'd9,  32'h1234_5000, 1,0,0,0,0, 32'd0,  1, 5'd15, 0, 32'h1234_5000};
    vecs[13] = '{CORE_ALU_OP_ADD,   32'hFFFF_FFFF,32'd7,  32'd0,         0,0,0,0,1, 32'd1,  1, 5'd16, 0, 32'd0};
    vecs[14] = '{CORE_ALU_OP_ADD,   32'd3,        32'd9,  32'd0,         0,0,0,1,0, 32'd0,  1, 5'd17, 1, 32'd3};
    vecs[15] = '{CORE_ALU_OP_ADD,   32'd1,        32'd9,  32'd4,         1,0,0,1,1, 32'd50, 1, 5'd18, 0, 32'd5};
    vecs[16] = '{CORE_ALU_OP_ADD,   32'd1,        32'd1,  32'd0,         0,0,0,0,0, 32'd0,  0, 5'd19, 1, 32'd2};

    op_list = '{CORE_ALU_OP_ADD, CORE_ALU_OP_SUB, CORE_ALU_OP_SLL, CORE_ALU_OP_SLT, CORE_ALU_OP_SLTU,
                CORE_ALU_OP_XOR, CORE_ALU_OP_SRL, CORE_ALU_OP_SRA, CORE_ALU_OP_OR, CORE_ALU_OP_AND,
                CORE_ALU_OP_PASSB, CORE_ALU_OP_MUL, CORE_ALU_OP_MULH, CORE_ALU_OP_MULHSU,
                CORE_ALU_OP_MULHU, CORE_ALU_OP_DIV, CORE_ALU_OP_DIVU, CORE_ALU_OP_REM, CORE_ALU_OP_REMU};

    // ---- reset state ----
    set_instr(CORE_ALU_OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", 32'(ex2mem_reg_wen), 32'd0);
    check("rst_waddr", 32'(ex2mem_reg_waddr), 32'd0);
    check("rst_result", ex2mem_alu_result, 32'd0);
    check("rst_ill", 32'(ex2mem_ill_instr), 32'd0);
    check("rst_stall", 32'(ex_stall), 32'd0);
    check("rst_state", 32'(mdu_state), 32'(MDU_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // ---- vector table ----
    for (int i = 0; i < 17; i++) begin
      set_instr(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].sel, vecs[i].f1m,
                vecs[i].f1w, vecs[i].f2m, vecs[i].f2w, vecs[i].wdata, vecs[i].wen, vecs[i].waddr,
                vecs[i].ill);
      tick();
      check($sformatf("vec%0d_wen", i), 32'(ex2mem_reg_wen), 32'(vecs[i].wen));
      check($sformatf("vec%0d_ill", i), 32'(ex2mem_ill_instr), 32'(vecs[i].ill));
      if (vecs[i].wen) begin
        check($sformatf("vec%0d_result", i), ex2mem_alu_result, vecs[i].exp);
        check($sformatf("vec%0d_waddr", i), 32'(ex2mem_reg_waddr), 32'(vecs[i].waddr));
      end
    end

    // ---- MDU opcode without wen must not start ----
    set_instr(CORE_ALU_OP_DIV, 32'd7, 32'd0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 5'd2, 1'b0);
    #1;
    check("nowen_stall", 32'(ex_stall), 32'd0);
    tick();
    check("nowen_state", 32'(mdu_state), 32'(MDU_IDLE));
    check("nowen_wen", 32'(ex2mem_reg_wen), 32'd0);

    // ---- hand-written MDU sequences (back to back) ----
    run_mdu(CORE_ALU_OP_MUL,  32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, "mul_m1x2");
    run_mdu(CORE_ALU_OP_MULH, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, "mulh_m1x2");
    run_mdu(CORE_ALU_OP_DIV,  32'd7, 32'd0, 1'b0, 1'b0, "div_by_zero");
    run_mdu(CORE_ALU_OP_REM,  32'd7, 32'd0, 1'b0, 1'b0, "rem_by_zero");
    run_mdu(CORE_ALU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
    run_mdu(CORE_ALU_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "rem_ovf");
    run_mdu(CORE_ALU_OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b1, "divu_fwd_wb");
    run_mdu(CORE_ALU_OP_REMU, 32'd100, 32'd7, 1'b1, 1'b1, "remu_fwd_wb");
    run_mdu(CORE_ALU_OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    run_mdu(CORE_ALU_OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "rem_neg");

    // ---- randomized ops against the model ----
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b, rs1, rs2, imm, wdata, opa, opb, exp;
      logic        sel, f1m, f1w, f2m, f2w, ill;
      logic [4:0]  waddr;
      op = op_list[$urandom_range(0, 18)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 40));
        default: ;
      endcase
      if (core_alu_is_mdu(op)) begin
        run_mdu(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end else begin
        rs1   = a;
        rs2   = b;
        imm   = $urandom;
        wdata = $urandom;
        sel   = 1'($urandom_range(0, 1));
        f1m   = 1'($urandom_range(0, 1));
        f1w   = 1'($urandom_range(0, 1));
        f2m   = 1'($urandom_range(0, 1));
        f2w   = 1'($urandom_range(0, 1));
        ill   = 1'($urandom_range(0, 1));
        waddr = 5'($urandom_range(1, 31));
        opa   = f1m ? last_exp : (f1w ? wdata : rs1);
        opb   = sel ? imm : (f2m ? last_exp : (f2w ? wdata : rs2));
        exp   = model(op, opa, opb);
        set_instr(op, rs1, rs2, imm, sel, f1m, f1w, f2m, f2w, wdata, 1'b1, waddr, ill);
        tick();
        check($sformatf("rnd%0d_result", i), ex2mem_alu_result, exp);
        check($sformatf("rnd%0d_ill", i), 32'(ex2mem_ill_instr), 32'(ill));
        check($sformatf("rnd%0d_waddr", i), 32'(ex2mem_reg_waddr), 32'(waddr));
        last_exp = exp;
      end
    end

    // ---- asynchronous reset mid-BUSY ----
    set_instr(CORE_ALU_OP_ADD, 32'h1234, 0, 0, 1'b1, 0, 0, 0, 0, 0, 1'b1, 5'd9, 1'b1);
    tick();
    check("prerst_result", ex2mem_alu_result, 32'h1234);
    set_instr(CORE_ALU_OP_DIVU, 32'd1000, 32'd3, 0, 0, 0, 0, 0, 0, 0, 1'b1, 5'd11, 1'b0);
    tick();
    repeat (10) tick();
    check("midbusy_state", 32'(mdu_state), 32'(MDU_BUSY));
    #2;
    rst = 1'b0;
    #1;
    check("arst_result", ex2mem_alu_result, 32'd0);
    check("arst_waddr", 32'(ex2mem_reg_waddr), 32'd0);
    check("arst_wen", 32'(ex2mem_reg_wen), 32'd0);
    check("arst_ill", 32'(ex2mem_ill_instr), 32'd0);
    check("arst_state", 32'(mdu_state), 32'(MDU_IDLE));
    id2ex_reg_wen = 1'b0;
    #1;
    check("arst_stall_drop", 32'(ex_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_state", 32'(mdu_state), 32'(MDU_IDLE));
    check("post_rst_stall", 32'(ex_stall), 32'd0);
    check("post_rst_wen", 32'(ex2mem_reg_wen), 32'd0);

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
